// File: rtl/cmd_rsp_fsm.sv
// Responder side of the command request/acknowledge handshake: captures a
// command, launches it to the executor, waits for done or timeout, acks once.
module cmd_rsp_fsm #(
  parameter int CMD_W   = 32,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_req,
  input  logic [CMD_W-1:0] cmd_word,
  output logic             cmd_ack,
  output logic             cmd_busy,
  output logic             exec_start,
  output logic [CMD_W-1:0] exec_cmd,
  input  logic             exec_done,
  input  logic             exec_err,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] cmd_count
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             cmd_ack_q, cmd_ack_d;
  logic             cmd_busy_q, cmd_busy_d;
  logic             exec_start_q, exec_start_d;
  logic [CMD_W-1:0] exec_cmd_q, exec_cmd_d;
  logic [1:0]       status_q, status_d;
  logic [CNT_W-1:0] cmd_count_q, cmd_count_d;
  logic [TW-1:0]    tmo_q, tmo_d;

  always_comb begin
    state_d      = state_q;
    cmd_ack_d    = 1'b0;
    exec_start_d = 1'b0;
    exec_cmd_d   = exec_cmd_q;
    status_d     = status_q;
    cmd_count_d  = cmd_count_q;
    tmo_d        = tmo_q;

    case (state_q)
      IDLE: begin
        if (cmd_req) begin
          state_d      = EXEC;
          exec_cmd_d   = cmd_word;
          exec_start_d = 1'b1;
          tmo_d        = '0;
        end
      end
      EXEC: begin
        tmo_d = tmo_q + TW'(1);
        // A done arriving on the timeout cycle still reports a normal completion.
        if (exec_done) begin
          status_d    = {1'b0, exec_err};
          cmd_ack_d   = 1'b1;
          cmd_count_d = cmd_count_q + CNT_W'(1);
          state_d     = RELEASE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          status_d    = 2'b10;
          cmd_ack_d   = 1'b1;
          cmd_count_d = cmd_count_q + CNT_W'(1);
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        if (!cmd_req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cmd_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cmd_ack_q    <= 1'b0;
      cmd_busy_q   <= 1'b0;
      exec_start_q <= 1'b0;
      exec_cmd_q   <= '0;
      status_q     <= 2'b00;
      cmd_count_q  <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ack_q    <= cmd_ack_d;
      cmd_busy_q   <= cmd_busy_d;
      exec_start_q <= exec_start_d;
      exec_cmd_q   <= exec_cmd_d;
      status_q     <= status_d;
      cmd_count_q  <= cmd_count_d;
      tmo_q        <= tmo_d;
    end
  end

  assign cmd_ack    = cmd_ack_q;
  assign cmd_busy   = cmd_busy_q;
  assign exec_start = exec_start_q;
  assign exec_cmd   = exec_cmd_q;
  assign status     = status_q;
  assign cmd_count  = cmd_count_q;

endmodule

// File: tb/tb_cmd_rsp_fsm.sv
// Directed self-checking bench for cmd_rsp_fsm (TIMEOUT=8, CNT_W=4).
module tb_cmd_rsp_fsm;

  localparam int CMD_W   = 32;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic             clk;
  logic             reset_n;
  logic             cmd_req;
  logic [CMD_W-1:0] cmd_word;
  logic             cmd_ack;
  logic             cmd_busy;
  logic             exec_start;
  logic [CMD_W-1:0] exec_cmd;
  logic             exec_done;
  logic             exec_err;
  logic [1:0]       status;
  logic [CNT_W-1:0] cmd_count;

  int n_cmp;
  int n_bad;
  int start_pulses;
  int ack_pulses;
  int cyc;
  int cap_cyc;
  int prev_cap;
  int base_start;
  int base_ack;
  logic [CNT_W-1:0] exp_count;
  logic [1:0]       exp_status;

  cmd_rsp_fsm #(
    .CMD_W  (CMD_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_req   (cmd_req),
    .cmd_word  (cmd_word),
    .cmd_ack   (cmd_ack),
    .cmd_busy  (cmd_busy),
    .exec_start(exec_start),
    .exec_cmd  (exec_cmd),
    .exec_done (exec_done),
    .exec_err  (exec_err),
    .status    (status),
    .cmd_count (cmd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    start_pulses = 0;
    ack_pulses   = 0;
  end
  always @(negedge clk) begin
    if (exec_start) start_pulses = start_pulses + 1;
    if (cmd_ack)    ack_pulses   = ack_pulses + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full handshake; done sampled dly edges after the capture edge.
  task automatic do_cmd(input logic [CMD_W-1:0] w, input int dly, input logic err);
    cmd_req  = 1'b1;
    cmd_word = w;
    step();
    cap_cyc = cyc;
    check("cap_start", exec_start, 1);
    check("cap_cmd", exec_cmd, w);
    check("cap_busy", cmd_busy, 1);
    check("cap_ack", cmd_ack, 0);
    repeat (dly - 1) step();
    exec_done = 1'b1;
    exec_err  = err;
    step();
    exec_done  = 1'b0;
    exec_err   = 1'b0;
    exp_count  = exp_count + 1'b1;
    exp_status = {1'b0, err};
    check("done_ack", cmd_ack, 1);
    check("done_status", status, exp_status);
    check("done_count", cmd_count, exp_count);
    step();
    check("ack_drop", cmd_ack, 0);
    check("ack_busy", cmd_busy, 1);
    cmd_req = 1'b0;
    step();
    check("idle_busy", cmd_busy, 0);
    $display("cmd %08h dly=%0d err=%0d -> status=%b count=%0d", w, dly, err, status, cmd_count);
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset_n    = 1'b0;
    cmd_req    = 1'b0;
    cmd_word   = '0;
    exec_done  = 1'b0;
    exec_err   = 1'b0;
    exp_count  = '0;
    exp_status = 2'b00;
    step();
    step();
    check("rst_ack", cmd_ack, 0);
    check("rst_busy", cmd_busy, 0);
    check("rst_start", exec_start, 0);
    check("rst_cmd", exec_cmd, 0);
    check("rst_status", status, 0);
    check("rst_count", cmd_count, 0);
    reset_n = 1'b1;
    step();

    // basic command, done 3 edges after capture
    base_start = start_pulses;
    base_ack   = ack_pulses;
    do_cmd(32'hDEAD_BEEF, 3, 1'b0);
    check("basic_starts", start_pulses - base_start, 1);
    check("basic_acks", ack_pulses - base_ack, 1);

    // error completion
    do_cmd(32'h1234_5678, 2, 1'b1);

    // timeout with late done in RELEASE
    cmd_req  = 1'b1;
    cmd_word = 32'hCAFE_0001;
    step();
    check("to_start", exec_start, 1);
    repeat (TIMEOUT - 1) step();
    check("to_noack_early", cmd_ack, 0);
    step();
    exp_count = exp_count + 1'b1;
    check("to_ack", cmd_ack, 1);
    check("to_status", status, 2'b10);
    check("to_count", cmd_count, exp_count);
    step();
    exec_done = 1'b1;
    exec_err  = 1'b1;
    step();
    exec_done = 1'b0;
    exec_err  = 1'b0;
    check("late_status", status, 2'b10);
    check("late_count", cmd_count, exp_count);
    check("late_ack", cmd_ack, 0);
    cmd_req = 1'b0;
    step();
    check("to_idle", cmd_busy, 0);
    $display("timeout cmd -> status=%b count=%0d", status, cmd_count);

    // held request, word changed mid-EXEC
    base_start = start_pulses;
    base_ack   = ack_pulses;
    cmd_req  = 1'b1;
    cmd_word = 32'hAAAA_5555;
    step();
    cmd_word = 32'h0BAD_F00D;
    step();
    check("held_cmd_stable", exec_cmd, 32'hAAAA_5555);
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    exp_count = exp_count + 1'b1;
    check("held_ack", cmd_ack, 1);
    check("held_count", cmd_count, exp_count);
    repeat (10) step();
    check("held_busy", cmd_busy, 1);
    check("held_starts", start_pulses - base_start, 1);
    check("held_acks", ack_pulses - base_ack, 1);
    check("held_cmd_after", exec_cmd, 32'hAAAA_5555);
    cmd_req = 1'b0;
    step();
    check("held_idle", cmd_busy, 0);
    $display("held cmd -> status=%b count=%0d", status, cmd_count);

    // reset during EXEC with request still high
    base_ack = ack_pulses;
    cmd_req  = 1'b1;
    cmd_word = 32'h0000_C0DE;
    step();
    step();
    reset_n = 1'b0;
    step();
    check("mid_rst_ack", cmd_ack, 0);
    check("mid_rst_busy", cmd_busy, 0);
    check("mid_rst_start", exec_start, 0);
    check("mid_rst_cmd", exec_cmd, 0);
    check("mid_rst_status", status, 0);
    check("mid_rst_count", cmd_count, 0);
    check("mid_rst_noack", ack_pulses - base_ack, 0);
    reset_n = 1'b1;
    step();
    check("rearm_start", exec_start, 1);
    check("rearm_cmd", exec_cmd, 32'h0000_C0DE);
    exec_done = 1'b1;
    step();
    exec_done  = 1'b0;
    exp_count  = 1;
    exp_status = 2'b00;
    check("rearm_ack", cmd_ack, 1);
    check("rearm_count", cmd_count, exp_count);
    step();
    cmd_req = 1'b0;
    step();
    check("rearm_idle", cmd_busy, 0);

    // counter wrap: 17 back-to-back commands from reset
    reset_n = 1'b0;
    step();
    reset_n   = 1'b1;
    exp_count = '0;
    prev_cap  = 0;
    for (int i = 0; i < 17; i++) begin
      do_cmd(32'h100 + i, 1, 1'b0);
      if (i > 0) check("wrap_spacing", cap_cyc - prev_cap, 4);
      prev_cap = cap_cyc;
    end
    check("wrap_count", cmd_count, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
